// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 33-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
module muldiv_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
    logic [1:0]  state;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] operand, rawA;
    logic        isDiv, qSign, rSign, zero;
    logic        accept, isSigned, fits;
    logic [31:0] absA, absB, quot, rem;
    logic [32:0] mulSum, partial, diff;
    logic [63:0] product;
    assign Busy = state != IDLE;
    always_comb begin
        accept   = Start && state == IDLE && !(Op[2] && Op[1]);
        isSigned = !Op[0];
        absA     = isSigned && A[31] ? -A : A;
        absB     = isSigned && B[31] ? -B : B;
        mulSum   = {1'b0, acc[63:32]} + {1'b0, acc[0] ? operand : 32'd0};
        // acc holds {remainder, dividend-shifting-into-quotient} while dividing
        partial  = {acc[63:32], acc[31]};
        diff     = partial - {1'b0, operand};
        fits     = partial >= {1'b0, operand};
        product  = qSign ? -acc : acc;
        quot     = qSign ? -acc[31:0] : acc[31:0];
        rem      = rSign ? -acc[63:32] : acc[63:32];
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            operand <= '0;
            rawA    <= '0;
            isDiv   <= 1'b0;
            qSign   <= 1'b0;
            rSign   <= 1'b0;
            zero    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            if (accept) begin
                if (Op[2]) begin
                    if (Op[0]) Lo <= A;
                    else Hi <= A;
                    Done <= 1'b1;
                end else begin
                    state   <= CALC;
                    count   <= '0;
                    isDiv   <= Op[1];
                    acc     <= {32'd0, absA};
                    operand <= absB;
                    rawA    <= A;
                    qSign   <= isSigned && (A[31] ^ B[31]);
                    rSign   <= isSigned && A[31];
                    zero    <= B == '0;
                end
            end else if (state == CALC) begin
                acc   <= isDiv ? {fits ? diff[31:0] : partial[31:0], acc[30:0], fits} : {mulSum, acc[31:1]};
                count <= count + 5'd1;
                if (count == 5'd31) state <= FIX;
            end else if (state == FIX) begin
                state   <= IDLE;
                Done    <= 1'b1;
                DivZero <= isDiv && zero;
                if (isDiv) begin
                    Lo <= zero ? 32'hFFFFFFFF : quot;
                    Hi <= zero ? rawA : rem;
                end else begin
                    {Hi, Lo} <= product;
                end
            end else if (state != IDLE) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    logic        Clock = 1'b0, Reset = 1'b0, Start = 1'b0;
    logic [2:0]  Op = 3'b000;
    logic [31:0] A = '0, B = '0;
    logic        Busy, Done, DivZero;
    logic [31:0] Hi, Lo;
    logic [31:0] mHi = '0, mLo = '0;
    int checks = 0, errors = 0;

    muldiv_unit dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input logic expDz, input int intr);
        int lat;
        logic busyOk, holdOk;
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clock);
        Start = 1'b0; A = $urandom; B = $urandom;
        check({tag, " busy_after_accept"}, 64'(Busy), 64'd1);
        check({tag, " done_low_after_accept"}, 64'(Done), 64'd0);
        lat = 0; busyOk = 1'b1; holdOk = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == intr) begin Start = 1'b1; Op = 3'b011; A = 32'd9; B = 32'd3; end
            if (k == intr + 1) Start = 1'b0;
            @(negedge Clock);
            if (Done) begin lat = k; break; end
            if (!Busy) busyOk = 1'b0;
            if (Hi !== mHi || Lo !== mLo) holdOk = 1'b0;
        end
        Start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " busy_throughout"}, 64'(busyOk), 64'd1);
        check({tag, " hilo_held"}, 64'(holdOk), 64'd1);
        check({tag, " busy_at_done"}, 64'(Busy), 64'd0);
        check({tag, " hi"}, 64'(Hi), 64'(expHi));
        check({tag, " lo"}, 64'(Lo), 64'(expLo));
        check({tag, " divzero"}, 64'(DivZero), 64'(expDz));
        mHi = expHi; mLo = expLo;
    endtask

    initial begin
        logic sawDone;
        #12;
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset divzero", 64'(DivZero), 64'd0);
        check("reset hi", 64'(Hi), 64'd0);
        check("reset lo", 64'(Lo), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        runOp("mult_neg3x5", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0);
        runOp("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0);
        runOp("div_neg7by2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
        runOp("divu_by_zero", 3'b011, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b1, 0);
        runOp("div_overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 0);
        @(negedge Clock);
        check("done single pulse", 64'(Done), 64'd0);
        Start = 1'b1; Op = 3'b100; A = 32'h12345678;
        @(negedge Clock);
        check("mthi done", 64'(Done), 64'd1);
        check("mthi busy", 64'(Busy), 64'd0);
        check("mthi hi", 64'(Hi), 64'h12345678);
        check("mthi lo kept", 64'(Lo), 64'h80000000);
        Op = 3'b101; A = 32'hCAFEF00D;
        @(negedge Clock);
        Start = 1'b0;
        check("mtlo done", 64'(Done), 64'd1);
        check("mtlo busy", 64'(Busy), 64'd0);
        check("mtlo hi kept", 64'(Hi), 64'h12345678);
        check("mtlo lo", 64'(Lo), 64'hCAFEF00D);
        @(negedge Clock);
        check("mt done ends", 64'(Done), 64'd0);
        mHi = 32'h12345678; mLo = 32'hCAFEF00D;
        Start = 1'b1; Op = 3'b110; A = 32'hDEADBEEF; B = 32'd1;
        @(negedge Clock);
        Start = 1'b0;
        @(negedge Clock);
        check("noop done", 64'(Done), 64'd0);
        check("noop busy", 64'(Busy), 64'd0);
        check("noop hi", 64'(Hi), 64'(mHi));
        check("noop lo", 64'(Lo), 64'(mLo));
        runOp("multu_6x7_ignore_start", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 10);
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            if (Done || Busy) sawDone = 1'b1;
        end
        check("ignored start not queued", 64'(sawDone), 64'd0);
        Start = 1'b1; Op = 3'b011; A = 32'd1000; B = 32'd7;
        @(negedge Clock);
        Start = 1'b0;
        repeat (14) @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        check("abort busy", 64'(Busy), 64'd0);
        check("abort done", 64'(Done), 64'd0);
        check("abort hi", 64'(Hi), 64'd0);
        check("abort lo", 64'(Lo), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        mHi = '0; mLo = '0;
        sawDone = 1'b0;
        repeat (50) begin
            @(negedge Clock);
            if (Done || Busy) sawDone = 1'b1;
        end
        check("no done after abort", 64'(sawDone), 64'd0);
        runOp("mult_after_abort", 3'b000, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
